// File: rtl/unidad_mul_div_pkg.sv
// Shared constants for the iterative RV32M multiply/divide unit:
// funct3 decodes, FSM encodings, iteration count and operand-sign helpers.
package unidad_mul_div_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam int unsigned N_ITER = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIN  = 2'd2
  } estado_e;

  function automatic logic es_div(input logic [2:0] f3);
    return f3[2];
  endfunction

  // rs1 is treated as signed by MULH, MULHSU, DIV and REM.
  function automatic logic signo_a(input logic [2:0] f3);
    logic r;
    case (f3)
      F3_MULH, F3_MULHSU, F3_DIV, F3_REM: r = 1'b1;
      default:                            r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic signo_b(input logic [2:0] f3);
    logic r;
    case (f3)
      F3_MULH, F3_DIV, F3_REM: r = 1'b1;
      default:                 r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/unidad_mul_div.sv
// Iterative RV32M multiply/divide: sign-magnitude operands, 32 shift-add or
// restoring shift-subtract steps on a shared 64-bit register, then sign fix-up.
module unidad_mul_div
  import unidad_mul_div_pkg::*;
#(
  parameter int ANCHO = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [2:0]       funct3_i,
  input  logic [ANCHO-1:0] op_a_i,
  input  logic [ANCHO-1:0] op_b_i,
  input  logic [4:0]       rd_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [ANCHO-1:0] result_o,
  output logic [4:0]       rd_o,
  output logic             wren_o
);

  localparam int W2 = 2 * ANCHO;
  localparam int CW = $clog2(ANCHO);

  estado_e          state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [W2-1:0]    acc_q, acc_d;
  logic [ANCHO-1:0] b_q, b_d;
  logic [2:0]       f3_q, f3_d;
  logic [4:0]       rd_q, rd_d;
  logic             neg_q, neg_d;
  logic             div0_q, div0_d;
  logic             ovf_q, ovf_d;
  logic [ANCHO-1:0] res_q, res_d;
  logic             done_q, done_d;
  logic             wren_q, wren_d;

  logic             a_sgn_s, b_sgn_s;
  logic [ANCHO-1:0] a_abs_s, b_abs_s;
  logic [ANCHO:0]   suma_s, resta_s;
  logic [W2-1:0]    paso_mul_s, paso_div_s;
  logic [W2-1:0]    prod_s;
  logic [ANCHO-1:0] coc_s, resto_s;

  // Operand conditioning for the capture in IDLE.
  always_comb begin
    a_sgn_s = signo_a(funct3_i) & op_a_i[ANCHO-1];
    b_sgn_s = signo_b(funct3_i) & op_b_i[ANCHO-1];
    if (a_sgn_s) begin
      a_abs_s = -op_a_i;
    end else begin
      a_abs_s = op_a_i;
    end
    if (b_sgn_s) begin
      b_abs_s = -op_b_i;
    end else begin
      b_abs_s = op_b_i;
    end
  end

  // One iteration of each algorithm; CALC picks the one matching funct3.
  always_comb begin
    suma_s  = {1'b0, acc_q[W2-1:ANCHO]} + {1'b0, b_q};
    resta_s = acc_q[W2-1:ANCHO-1] - {1'b0, b_q};
    if (acc_q[0]) begin
      paso_mul_s = {suma_s, acc_q[ANCHO-1:1]};
    end else begin
      paso_mul_s = {1'b0, acc_q[W2-1:1]};
    end
    // The shifted partial remainder needs ANCHO+1 bits before the trial subtract.
    if (!resta_s[ANCHO]) begin
      paso_div_s = {resta_s[ANCHO-1:0], acc_q[ANCHO-2:0], 1'b1};
    end else begin
      paso_div_s = {acc_q[W2-2:0], 1'b0};
    end
  end

  // Sign correction of the finished magnitudes.
  always_comb begin
    if (neg_q) begin
      prod_s  = -acc_q;
      coc_s   = -acc_q[ANCHO-1:0];
      resto_s = -acc_q[W2-1:ANCHO];
    end else begin
      prod_s  = acc_q;
      coc_s   = acc_q[ANCHO-1:0];
      resto_s = acc_q[W2-1:ANCHO];
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    b_d     = b_q;
    f3_d    = f3_q;
    rd_d    = rd_q;
    neg_d   = neg_q;
    div0_d  = div0_q;
    ovf_d   = ovf_q;
    res_d   = res_q;
    done_d  = 1'b0;
    wren_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          f3_d   = funct3_i;
          rd_d   = rd_i;
          cnt_d  = '0;
          div0_d = (op_b_i == {ANCHO{1'b0}});
          ovf_d  = signo_a(funct3_i) & es_div(funct3_i)
                   & (op_a_i == {1'b1, {(ANCHO-1){1'b0}}})
                   & (op_b_i == {ANCHO{1'b1}});
          if (es_div(funct3_i)) begin
            acc_d = {{ANCHO{1'b0}}, a_abs_s};
            b_d   = b_abs_s;
            if (funct3_i[1]) begin
              neg_d = a_sgn_s;
            end else begin
              neg_d = a_sgn_s ^ b_sgn_s;
            end
          end else begin
            acc_d = {{ANCHO{1'b0}}, b_abs_s};
            b_d   = a_abs_s;
            neg_d = a_sgn_s ^ b_sgn_s;
          end
          state_d = ST_CALC;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_CALC: begin
        if (es_div(f3_q)) begin
          acc_d = paso_div_s;
        end else begin
          acc_d = paso_mul_s;
        end
        if (cnt_q == CW'(N_ITER - 1)) begin
          state_d = ST_FIN;
        end else begin
          cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        end
      end

      ST_FIN: begin
        // Divide-by-zero remainder needs no special case: |a| re-signed is a.
        case (f3_q)
          F3_MUL: res_d = prod_s[ANCHO-1:0];
          F3_MULH, F3_MULHSU, F3_MULHU: res_d = prod_s[W2-1:ANCHO];
          F3_DIV, F3_DIVU: begin
            if (div0_q) begin
              res_d = {ANCHO{1'b1}};
            end else if (ovf_q) begin
              res_d = {1'b1, {(ANCHO-1){1'b0}}};
            end else begin
              res_d = coc_s;
            end
          end
          F3_REM, F3_REMU: begin
            if (ovf_q) begin
              res_d = {ANCHO{1'b0}};
            end else begin
              res_d = resto_s;
            end
          end
          default: res_d = res_q;
        endcase
        done_d  = 1'b1;
        wren_d  = (rd_q != 5'd0);
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      b_q     <= '0;
      f3_q    <= 3'b000;
      rd_q    <= 5'd0;
      neg_q   <= 1'b0;
      div0_q  <= 1'b0;
      ovf_q   <= 1'b0;
      res_q   <= '0;
      done_q  <= 1'b0;
      wren_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      b_q     <= b_d;
      f3_q    <= f3_d;
      rd_q    <= rd_d;
      neg_q   <= neg_d;
      div0_q  <= div0_d;
      ovf_q   <= ovf_d;
      res_q   <= res_d;
      done_q  <= done_d;
      wren_q  <= wren_d;
    end
  end

  assign busy_o   = (state_q != ST_IDLE);
  assign done_o   = done_q;
  assign wren_o   = wren_q;
  assign result_o = res_q;
  assign rd_o     = rd_q;

endmodule

// File: tb/tb_unidad_mul_div.sv
// Directed, table-driven bench for unidad_mul_div with hand-computed results,
// plus sequences for ignored start, back-to-back start and mid-operation reset.
`timescale 1ns/1ps
module tb_unidad_mul_div;
  import unidad_mul_div_pkg::*;

  logic        clk;
  logic        rst_i;
  logic        start_i;
  logic [2:0]  funct3_i;
  logic [31:0] op_a_i;
  logic [31:0] op_b_i;
  logic [4:0]  rd_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] result_o;
  logic [4:0]  rd_o;
  logic        wren_o;

  int total;
  int bad;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[16];

  unidad_mul_div #(.ANCHO(32)) dut (
    .clk_i   (clk),
    .rst_i   (rst_i),
    .start_i (start_i),
    .funct3_i(funct3_i),
    .op_a_i  (op_a_i),
    .op_b_i  (op_b_i),
    .rd_i    (rd_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .result_o(result_o),
    .rd_o    (rd_o),
    .wren_o  (wren_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge; drives start there and returns at the negedge of the done cycle.
  task automatic run_op(input vec_t v, input int pulse_at, input string tag);
    int k;
    bit seen;
    bit busy_ok;
    start_i  = 1'b1;
    funct3_i = v.f3;
    op_a_i   = v.a;
    op_b_i   = v.b;
    rd_i     = v.rd;
    @(negedge clk);
    start_i = 1'b0;
    k = 1;
    seen = 1'b0;
    busy_ok = 1'b1;
    while (!seen && k <= 60) begin
      if (done_o === 1'b1) begin
        seen = 1'b1;
      end else begin
        if (busy_o !== 1'b1) busy_ok = 1'b0;
        if (k == pulse_at) begin
          start_i  = 1'b1;
          funct3_i = F3_MULHU;
          op_a_i   = 32'h0000_0001;
          op_b_i   = 32'h0000_0001;
          rd_i     = 5'd1;
        end else begin
          start_i = 1'b0;
        end
        @(negedge clk);
        k++;
      end
    end
    start_i = 1'b0;
    chk({tag, " latency"}, 32'(k), 32'd34);
    chk({tag, " busy_during"}, {31'd0, busy_ok}, 32'd1);
    chk({tag, " busy_at_done"}, {31'd0, busy_o}, 32'd0);
    chk({tag, " result"}, result_o, v.exp);
    chk({tag, " rd_o"}, {27'd0, rd_o}, {27'd0, v.rd});
    chk({tag, " wren"}, {31'd0, wren_o}, {31'd0, (v.rd != 5'd0)});
  endtask

  initial begin
    vec_t v;
    bit   spur;
    total = 0;
    bad   = 0;

    vecs[0]  = '{F3_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB};
    vecs[1]  = '{F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,  32'hFFFF_FFFE};
    vecs[2]  = '{F3_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  32'h0000_0000};
    vecs[3]  = '{F3_MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, 5'd8,  32'hFFFF_FFFF};
    vecs[4]  = '{F3_DIV,    32'hFFFF_FFF9, 32'h0000_0002, 5'd9,  32'hFFFF_FFFD};
    vecs[5]  = '{F3_REM,    32'hFFFF_FFF9, 32'h0000_0002, 5'd10, 32'hFFFF_FFFF};
    vecs[6]  = '{F3_REMU,   32'h0000_0007, 32'h0000_0002, 5'd11, 32'h0000_0001};
    vecs[7]  = '{F3_DIVU,   32'h0000_0005, 32'h0000_0000, 5'd12, 32'hFFFF_FFFF};
    vecs[8]  = '{F3_REM,    32'h0000_0005, 32'h0000_0000, 5'd13, 32'h0000_0005};
    vecs[9]  = '{F3_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h8000_0000};
    vecs[10] = '{F3_REM,    32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h0000_0000};
    vecs[11] = '{F3_DIVU,   32'h0000_0064, 32'h0000_0007, 5'd16, 32'h0000_000E};
    vecs[12] = '{F3_REMU,   32'h0000_0064, 32'h0000_0007, 5'd17, 32'h0000_0002};
    vecs[13] = '{F3_MULHU,  32'h8000_0000, 32'h0000_0004, 5'd18, 32'h0000_0002};
    vecs[14] = '{F3_DIV,    32'h8000_0000, 32'h0000_0000, 5'd19, 32'hFFFF_FFFF};
    vecs[15] = '{F3_REM,    32'h8000_0000, 32'h0000_0000, 5'd31, 32'h8000_0000};

    rst_i = 1'b1;
    start_i = 1'b0;
    funct3_i = 3'b000;
    op_a_i = 32'd0;
    op_b_i = 32'd0;
    rd_i = 5'd0;
    @(negedge clk);
    @(negedge clk);
    chk("reset busy", {31'd0, busy_o}, 32'd0);
    chk("reset done", {31'd0, done_o}, 32'd0);
    chk("reset wren", {31'd0, wren_o}, 32'd0);
    chk("reset result", result_o, 32'd0);
    chk("reset rd_o", {27'd0, rd_o}, 32'd0);
    rst_i = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 16; i++) begin
      run_op(vecs[i], 0, $sformatf("vec%0d", i));
      @(negedge clk);
      chk($sformatf("vec%0d done_one_cycle", i), {30'd0, done_o, wren_o}, 32'd0);
      chk($sformatf("vec%0d result_hold", i), result_o, vecs[i].exp);
    end

    // Start pulse while busy is ignored.
    v = '{F3_MUL, 32'h0000_0006, 32'h0000_0009, 5'd3, 32'h0000_0036};
    run_op(v, 5, "ignore_start");

    // Back-to-back: new start accepted in the done cycle.
    v = '{F3_DIVU, 32'h0000_0010, 32'h0000_0003, 5'd4, 32'h0000_0005};
    run_op(v, 0, "b2b_first");
    v = '{F3_REMU, 32'h0000_0010, 32'h0000_0003, 5'd20, 32'h0000_0001};
    run_op(v, 0, "b2b_second");
    @(negedge clk);

    // Reset in the middle of an operation, with an ignored start in cycle 5.
    start_i = 1'b1;
    funct3_i = F3_MUL;
    op_a_i = 32'h0000_0007;
    op_b_i = 32'h0000_0003;
    rd_i = 5'd9;
    @(negedge clk);
    start_i = 1'b0;
    for (int k = 1; k < 10; k++) begin
      start_i = (k == 5);
      @(negedge clk);
    end
    start_i = 1'b0;
    chk("pre_reset busy", {31'd0, busy_o}, 32'd1);
    rst_i = 1'b1;
    #1;
    chk("abort busy", {31'd0, busy_o}, 32'd0);
    chk("abort done", {31'd0, done_o}, 32'd0);
    chk("abort wren", {31'd0, wren_o}, 32'd0);
    chk("abort rd_o", {27'd0, rd_o}, 32'd0);
    @(negedge clk);
    rst_i = 1'b0;
    spur = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done_o !== 1'b0 || wren_o !== 1'b0 || busy_o !== 1'b0) spur = 1'b1;
    end
    chk("abort no_writeback", {31'd0, spur}, 32'd0);

    v = '{F3_MUL, 32'h0000_0003, 32'h0000_0004, 5'd0, 32'h0000_000C};
    run_op(v, 0, "post_reset_x0");
    chk("post_reset_x0 done", {31'd0, done_o}, 32'd1);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
